// File: rtl/bus_timer_if.sv
// bus_timer_if: processor data-bus slice seen by the interval timer
interface bus_timer_if;
    logic        cs;
    logic        W;
    logic [1:0]  Addr;
    logic [15:0] Wdata;
    logic [15:0] Rdata;
    logic        Done;
    modport master (output cs, W, Addr, Wdata, input Rdata, Done);
    modport slave  (input cs, W, Addr, Wdata, output Rdata, Done);
endinterface

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped prescaled down-counter with sticky expiry flag and optional auto-reload
module bus_timer #(
    parameter int PRESCALE = 50000
) (
    input  logic       Clock,
    input  logic       Resetn,
    bus_timer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [15:0] TICK_AT = 16'(PRESCALE - 1);
    state_t      state_q, state_d;
    logic [15:0] load_q, load_d;
    logic [15:0] count_q, count_d;
    logic [15:0] presc_q, presc_d;
    logic        auto_q, auto_d;
    logic        done_q, done_d;
    logic        wr, tick, expire;
    // next state: prescaler/tick countdown first, then bus writes override (start/stop beat a tick, STATUS clear loses to expiry)
    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        count_d = count_q;
        presc_d = presc_q;
        auto_d  = auto_q;
        done_d  = done_q;
        wr      = bus.cs && bus.W;
        tick    = (state_q == RUN) && (presc_q == TICK_AT);
        expire  = tick && (count_q <= 16'd1);
        if (state_q == RUN)
            presc_d = tick ? '0 : presc_q + 16'd1;
        if (tick) begin
            count_d = expire ? (auto_q ? load_q : '0) : count_q - 16'd1;
            state_d = (expire && !auto_q) ? IDLE : RUN;
            done_d  = done_q || expire;
        end
        if (wr) begin
            case (bus.Addr)
                2'd0: load_d = bus.Wdata;
                2'd2: begin
                    auto_d  = bus.Wdata[1];
                    presc_d = '0;
                    done_d  = done_q;
                    count_d = bus.Wdata[0] ? load_q : count_q;
                    state_d = bus.Wdata[0] ? RUN : IDLE;
                end
                2'd3: done_d = expire;
                default: ;
            endcase
        end
    end
    // state registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= IDLE;
            load_q  <= '0;
            count_q <= '0;
            presc_q <= '0;
            auto_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            count_q <= count_d;
            presc_q <= presc_d;
            auto_q  <= auto_d;
            done_q  <= done_d;
        end
    end
    // combinational read mux, independent of cs and W
    always_comb begin
        bus.Rdata = (bus.Addr == 2'd0) ? load_q :
                    (bus.Addr == 2'd1) ? count_q :
                    (bus.Addr == 2'd2) ? {14'b0, auto_q, state_q == RUN} :
                                         {15'b0, done_q};
    end
    assign bus.Done = done_q;
endmodule
